// File: rtl/port_stream_fifo_if.sv
// -----------------------------------------------------------------------------
// port_stream_fifo_if
// Groups the producer-side and consumer-side valid/ready signals of
// port_stream_fifo, together with the occupancy count.
//
// Parameters:
//   WIDTH - data word width in bits
//   DEPTH - FIFO depth, which sets the width of count
//
// Signals:
//   in_valid / in_ready / in_data     producer handshake and word
//   out_valid / out_ready / out_data  consumer handshake and head word
//   count                             occupancy, 0..DEPTH
//
// Modports:
//   master - the environment (producer and consumer)
//   slave  - the FIFO
// -----------------------------------------------------------------------------
interface port_stream_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);

  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

endinterface

// File: rtl/port_stream_fifo.sv
// -----------------------------------------------------------------------------
// port_stream_fifo
// Synchronous valid/ready FIFO. It buffers WIDTH-bit words from a producer and
// presents them in order to a consumer. Storage is a DEPTH-entry register
// array addressed by wrapping write/read pointers. Occupancy is kept in its
// own counter, so full and empty never have to be decoded from the pointers.
//
// Parameters:
//   WIDTH - data word width (>= 1)
//   DEPTH - number of entries (power of two, >= 2)
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - port_stream_fifo_if.slave (in_*/out_* handshakes, count)
//
// Build option:
//   PORT_FIFO_BYPASS_EN - when this macro is defined, the FIFO is empty and
//   out_ready is high, the incoming word passes combinationally to the output
//   and nothing is stored. When the macro is not defined, no combinational path
//   runs from in to out.
// -----------------------------------------------------------------------------
module port_stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  port_stream_fifo_if.slave     bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    count_q, count_d;

  logic             full_s;
  logic             empty_s;
  logic             bypass_s;
  logic             in_ready_s;
  logic             out_valid_s;
  logic [WIDTH-1:0] out_data_s;
  logic             push_s;
  logic             pop_s;
  logic             store_s;
  logic             deq_s;

  assign full_s  = (count_q == CW'(DEPTH));
  assign empty_s = (count_q == {CW{1'b0}});

  // in_ready depends only on state and rst, never on out_ready. As a result,
  // a pop cannot free a slot for a push in the same cycle.
  assign in_ready_s = ~full_s & ~rst;

`ifdef PORT_FIFO_BYPASS_EN
  // Pass-through is gated by rst because in_ready is low during reset, so the
  // producer side cannot complete a transfer then.
  assign bypass_s = empty_s & bus.out_ready & ~rst;
`else
  assign bypass_s = 1'b0;
`endif

  // Consumer-side view: the head entry, or the live input word when it bypasses the array.
  always_comb begin
    out_valid_s = ~empty_s;
    out_data_s  = mem_q[rp_q];
    if (bypass_s) begin
      out_valid_s = bus.in_valid;
      out_data_s  = bus.in_data;
    end else begin
      out_valid_s = ~empty_s;
      out_data_s  = mem_q[rp_q];
    end
  end

  assign push_s  = bus.in_valid & in_ready_s;
  assign pop_s   = out_valid_s & bus.out_ready;
  // A word that bypasses the array is consumed in the same cycle. It is
  // neither written to nor read from storage.
  assign store_s = push_s & ~bypass_s;
  assign deq_s   = pop_s & ~bypass_s;

  // Next-state values for the pointers and the occupancy counter.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (store_s) begin
      wp_d = wp_q + AW'(1);
    end else begin
      wp_d = wp_q;
    end
    if (deq_s) begin
      rp_d = rp_q + AW'(1);
    end else begin
      rp_d = rp_q;
    end
    case ({store_s, deq_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and counter registers. Reset empties the queue logically.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= {AW{1'b0}};
      rp_q    <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Storage array. Reset does not clear it. store_s stays low during reset
  // because in_ready is low then.
  always_ff @(posedge clk) begin
    if (store_s) begin
      mem_q[wp_q] <= bus.in_data;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = out_data_s;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_port_stream_fifo.sv
// -----------------------------------------------------------------------------
// tb_port_stream_fifo
// Drives port_stream_fifo with directed steps followed by a random phase.
// A queue-based reference model predicts in_ready, out_valid, out_data and
// count. When PORT_FIFO_BYPASS_EN is defined, the model also predicts the
// empty-FIFO pass-through.
// -----------------------------------------------------------------------------
module tb_port_stream_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
`ifdef PORT_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst;

  port_stream_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  port_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int unsigned n_tests;
  int unsigned n_fail;
  logic [WIDTH-1:0] mq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, check the outputs at the falling edge, then
  // advance the model on the rising edge.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic r,
                       input logic rs, input string tag);
    int  sz;
    bit  byp;
    bit  exp_rdy;
    bit  exp_vld;
    bit  do_push;
    bit  do_pop;
    logic [WIDTH-1:0] exp_data;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    rst           = rs;
    @(negedge clk);
    sz       = mq.size();
    byp      = BYP && (sz == 0) && r && !rs;
    exp_rdy  = !rs && (sz < DEPTH);
    exp_vld  = byp ? v : (sz > 0);
    exp_data = byp ? d : ((sz > 0) ? mq[0] : '0);
    chk({tag, ":in_ready"},  32'(bus.in_ready),  32'(exp_rdy));
    chk({tag, ":out_valid"}, 32'(bus.out_valid), 32'(exp_vld));
    chk({tag, ":count"},     32'(bus.count),     32'(sz));
    if (exp_vld) begin
      chk({tag, ":out_data"}, 32'(bus.out_data), 32'(exp_data));
    end
    @(posedge clk);
    if (rs) begin
      mq.delete();
    end else if (!(byp && v)) begin
      do_pop  = r && (sz > 0);
      do_push = v && (sz < DEPTH);
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(d);
    end
    #1;
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    clk           = 1'b0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset, then idle.
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "rst0");
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "rst1");
    cycle(1'b0, 8'h00, 1'b0, 1'b0, "idle");

    // Fill to full while out_ready is low. The fifth word is refused.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0, "fill");
    chk("full_count", 32'(bus.count), 32'd4);
    cycle(1'b1, 8'h55, 1'b0, 1'b0, "full_push");
    chk("full_hold_count", 32'(bus.count), 32'd4);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain");
    chk("drain_count", 32'(bus.count), 32'd0);

    // Full FIFO with a simultaneous pop: the pop happens and the push does not.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0, "refill");
    cycle(1'b1, 8'h66, 1'b1, 1'b0, "fullpop");
    chk("fullpop_count", 32'(bus.count), 32'd3);
    chk("fullpop_rdy", 32'(bus.in_ready), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, "after_fullpop");
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain2");

    // Steady streaming across two pointer wraps.
    for (int i = 1; i <= 10; i++) cycle(1'b1, 8'(i), 1'b1, 1'b0, "stream");
    chk("stream_count", 32'(bus.count), BYP ? 32'd0 : 32'd1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "stream_tail");

    // Reset in mid-stream discards the queued words.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hA1 + i), 1'b0, 1'b0, "pre_rst");
    cycle(1'b1, 8'hEE, 1'b0, 1'b1, "mid_rst");
    chk("mid_rst_count", 32'(bus.count), 32'd0);
    cycle(1'b1, 8'hAA, 1'b0, 1'b0, "post_rst_push");
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "post_rst_pop");

    // Empty FIFO with both sides ready. This is a pass-through only when
    // bypass is built in.
    cycle(1'b1, 8'h5A, 1'b1, 1'b0, "empty_both");
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "empty_both_tail");

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 49) == 0), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
